// File: rtl/ytydla_conv_cmac_accu_ctrl.sv
// ---------------------------------------------------------------------------
// ytydla_conv_cmac_accu_ctrl
//
// Sequencer for the CMAC accumulation adder tree. It accepts tree operations
// from the CMAC, follows each one through the fixed-latency tree with a
// shift register of issue flags, and sums cfg_atomic_num tree results into
// one output element. Finished elements are queued in a small output FIFO.
// The adder tree cannot stall, so issue is gated by FIFO credits. A credit is
// reserved when a group starts and is released when that group's element is
// pushed. Every group that starts therefore has a FIFO slot waiting for it.
//
// Ports
//   ytydla_core_clk / ytydla_core_rst : clock, synchronous active-high reset
//   cfg_start, cfg_atomic_num,
//   cfg_out_num                       : layer start pulse and layer config
//   cmac2ctrl_valid / ctrl2cmac_ready : tree-operation issue handshake
//   tree2ctrl_sum                     : adder-tree result, TREE_LAT after issue
//   accu2dp_valid / accu2dp_data /
//   dp2accu_ready                     : output element stream
//   ctrl_busy                         : layer in progress
//   ctrl_done                         : one-cycle pulse when a layer ends
//   ctrl_err                          : sticky overflow / bad-config flag
// ---------------------------------------------------------------------------
module ytydla_conv_cmac_accu_ctrl #(
    parameter int DATA_W      = 32,
    parameter int TREE_LAT    = 4,
    parameter int CNT_W       = 8,
    parameter int OUT_CNT_W   = 16,
    parameter int OFIFO_DEPTH = 4
) (
    input  logic                 ytydla_core_clk,
    input  logic                 ytydla_core_rst,
    input  logic                 cfg_start,
    input  logic [CNT_W-1:0]     cfg_atomic_num,
    input  logic [OUT_CNT_W-1:0] cfg_out_num,
    input  logic                 cmac2ctrl_valid,
    output logic                 ctrl2cmac_ready,
    input  logic [DATA_W-1:0]    tree2ctrl_sum,
    output logic                 accu2dp_valid,
    output logic [DATA_W-1:0]    accu2dp_data,
    input  logic                 dp2accu_ready,
    output logic                 ctrl_busy,
    output logic                 ctrl_done,
    output logic                 ctrl_err
);

    localparam int PTR_W = (OFIFO_DEPTH > 1) ? $clog2(OFIFO_DEPTH) : 1;
    localparam int CRD_W = PTR_W + 1;
    localparam logic [CRD_W-1:0] DEPTH_C = CRD_W'(OFIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Registered state
    state_t                state_q,    state_d;
    logic [CNT_W-1:0]      atomic_q,   atomic_d;
    logic [OUT_CNT_W-1:0]  out_num_q,  out_num_d;
    logic [CNT_W-1:0]      iss_atom_q, iss_atom_d;  // issues made in the current group
    logic [OUT_CNT_W-1:0]  iss_out_q,  iss_out_d;   // groups fully issued
    logic [CRD_W-1:0]      rsv_q,      rsv_d;       // groups started, not yet pushed
    logic [TREE_LAT-1:0]   pipe_q,     pipe_d;      // issue flags in flight in the tree
    logic [CNT_W-1:0]      ret_cnt_q,  ret_cnt_d;   // returns consumed in current group
    logic [DATA_W-1:0]     acc_q,      acc_d;
    logic [PTR_W-1:0]      wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q,   rd_ptr_d;
    logic [CRD_W-1:0]      fifo_cnt_q, fifo_cnt_d;
    logic [DATA_W-1:0]     last_q,     last_d;      // last popped element, shown when empty
    logic                  busy_q,     busy_d;
    logic                  done_q,     done_d;
    logic                  err_q,      err_d;

    logic [DATA_W-1:0]     fifo_mem_q [OFIFO_DEPTH];

    // Combinational helpers
    logic                  mid_grp;
    logic                  credit_free;
    logic                  issue_rdy;
    logic                  issue;
    logic                  grp_issued;
    logic                  last_issue;
    logic                  ret;
    logic                  ret_first;
    logic [DATA_W-1:0]     add_res;
    logic                  ovf;
    logic [DATA_W-1:0]     grp_val;
    logic                  push;
    logic                  pop;
    logic                  start_ok;
    logic                  start_bad;
    logic                  start_idle;

    always_comb begin : handshake_logic
        mid_grp     = (iss_atom_q != '0);
        // fifo_cnt + rsv never exceeds the depth, so the sum cannot wrap.
        credit_free = ((fifo_cnt_q + rsv_q) < DEPTH_C);
        // A group already under way owns its credit and may keep issuing.
        issue_rdy   = (state_q == ST_RUN) && (iss_out_q != out_num_q) &&
                      (mid_grp || credit_free);
        issue       = issue_rdy && cmac2ctrl_valid;
        grp_issued  = issue && (iss_atom_q == (atomic_q - CNT_W'(1)));
        last_issue  = grp_issued && (iss_out_q == (out_num_q - OUT_CNT_W'(1)));

        ret         = pipe_q[TREE_LAT-1];
        ret_first   = (ret_cnt_q == '0);
        add_res     = acc_q + tree2ctrl_sum;
        // Signed overflow: both operands have the same sign and the result
        // has the other sign.
        ovf         = ret && !ret_first &&
                      (acc_q[DATA_W-1] == tree2ctrl_sum[DATA_W-1]) &&
                      (add_res[DATA_W-1] != acc_q[DATA_W-1]);
        grp_val     = ret_first ? tree2ctrl_sum : add_res;
        push        = ret && (ret_cnt_q == (atomic_q - CNT_W'(1)));
        pop         = (fifo_cnt_q != '0) && dp2accu_ready;

        start_idle  = cfg_start && (state_q == ST_IDLE);
        start_ok    = start_idle && (cfg_atomic_num != '0) && (cfg_out_num != '0);
        start_bad   = start_idle && !start_ok;
    end

    always_comb begin : next_state
        // NOTE: every variable gets its hold value first, so no branch can
        // leave one unassigned and infer a latch.
        state_d    = state_q;
        atomic_d   = atomic_q;
        out_num_d  = out_num_q;
        iss_atom_d = iss_atom_q;
        iss_out_d  = iss_out_q;
        rsv_d      = rsv_q;
        pipe_d     = (pipe_q << 1) | TREE_LAT'(issue);
        ret_cnt_d  = ret_cnt_q;
        acc_d      = acc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        last_d     = last_q;
        err_d      = err_q;

        // Issue bookkeeping
        if (start_ok) begin
            atomic_d   = cfg_atomic_num;
            out_num_d  = cfg_out_num;
            iss_atom_d = '0;
            iss_out_d  = '0;
        end else if (issue) begin
            if (grp_issued) begin
                iss_atom_d = '0;
                iss_out_d  = iss_out_q + OUT_CNT_W'(1);
            end else begin
                iss_atom_d = iss_atom_q + CNT_W'(1);
            end
        end

        // The first issue of a group reserves a credit. The push of that
        // group releases it.
        case ({issue && !mid_grp, push})
            2'b10:   rsv_d = rsv_q + CRD_W'(1);
            2'b01:   rsv_d = rsv_q - CRD_W'(1);
            default: rsv_d = rsv_q;
        endcase

        // Accumulation of tree returns
        if (ret) begin
            if (push) begin
                ret_cnt_d = '0;
            end else begin
                ret_cnt_d = ret_cnt_q + CNT_W'(1);
                acc_d     = grp_val;
            end
        end

        // Output FIFO. Pointer wrap relies on a power-of-two depth.
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            last_d   = fifo_mem_q[rd_ptr_q];
        end
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CRD_W'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CRD_W'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase

        // Sticky error: cleared only by an accepted start
        if (start_ok) begin
            err_d = 1'b0;
        end
        if (start_bad || ovf) begin
            err_d = 1'b1;
        end

        // Layer FSM
        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_issue) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((pipe_q == '0) && (ret_cnt_q == '0) && (fifo_cnt_q == '0)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE) || start_bad;
    end

    always_ff @(posedge ytydla_core_clk) begin
        if (ytydla_core_rst) begin
            // NOTE: sequential state uses non-blocking assignments only, so
            // every flop samples the values from before the edge.
            state_q    <= ST_IDLE;
            atomic_q   <= '0;
            out_num_q  <= '0;
            iss_atom_q <= '0;
            iss_out_q  <= '0;
            rsv_q      <= '0;
            pipe_q     <= '0;
            ret_cnt_q  <= '0;
            acc_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            last_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            atomic_q   <= atomic_d;
            out_num_q  <= out_num_d;
            iss_atom_q <= iss_atom_d;
            iss_out_q  <= iss_out_d;
            rsv_q      <= rsv_d;
            pipe_q     <= pipe_d;
            ret_cnt_q  <= ret_cnt_d;
            acc_q      <= acc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            last_q     <= last_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // NOTE: the FIFO storage has no reset. Reset empties the FIFO through
    // the pointers and count, and an entry is never read before it is written.
    always_ff @(posedge ytydla_core_clk) begin
        if (!ytydla_core_rst && push) begin
            fifo_mem_q[wr_ptr_q] <= grp_val;
        end
    end

    assign ctrl2cmac_ready = issue_rdy;
    assign accu2dp_valid   = (fifo_cnt_q != '0);
    assign accu2dp_data    = (fifo_cnt_q != '0) ? fifo_mem_q[rd_ptr_q] : last_q;
    assign ctrl_busy       = busy_q;
    assign ctrl_done       = done_q;
    assign ctrl_err        = err_q;

endmodule

// File: tb/tb_ytydla_conv_cmac_accu_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for ytydla_conv_cmac_accu_ctrl.
// Random valid/ready/sum stimulus is compared every cycle against a
// transaction-level reference model. The model tracks issues as counts and
// due times, groups as lists of sums, and the FIFO as a queue. Directed
// scenarios add explicit checks on top.
// ---------------------------------------------------------------------------
module tb_ytydla_conv_cmac_accu_ctrl;

    localparam int DATA_W      = 32;
    localparam int TREE_LAT    = 4;
    localparam int CNT_W       = 8;
    localparam int OUT_CNT_W   = 16;
    localparam int OFIFO_DEPTH = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 cfg_start;
    logic [CNT_W-1:0]     cfg_atomic_num;
    logic [OUT_CNT_W-1:0] cfg_out_num;
    logic                 cmac2ctrl_valid;
    logic                 ctrl2cmac_ready;
    logic [DATA_W-1:0]    tree2ctrl_sum;
    logic                 accu2dp_valid;
    logic [DATA_W-1:0]    accu2dp_data;
    logic                 dp2accu_ready;
    logic                 ctrl_busy;
    logic                 ctrl_done;
    logic                 ctrl_err;

    always #5 clk = ~clk;

    ytydla_conv_cmac_accu_ctrl #(
        .DATA_W      (DATA_W),
        .TREE_LAT    (TREE_LAT),
        .CNT_W       (CNT_W),
        .OUT_CNT_W   (OUT_CNT_W),
        .OFIFO_DEPTH (OFIFO_DEPTH)
    ) dut (
        .ytydla_core_clk (clk),
        .ytydla_core_rst (rst),
        .cfg_start       (cfg_start),
        .cfg_atomic_num  (cfg_atomic_num),
        .cfg_out_num     (cfg_out_num),
        .cmac2ctrl_valid (cmac2ctrl_valid),
        .ctrl2cmac_ready (ctrl2cmac_ready),
        .tree2ctrl_sum   (tree2ctrl_sum),
        .accu2dp_valid   (accu2dp_valid),
        .accu2dp_data    (accu2dp_data),
        .dp2accu_ready   (dp2accu_ready),
        .ctrl_busy       (ctrl_busy),
        .ctrl_done       (ctrl_done),
        .ctrl_err        (ctrl_err)
    );

    // ------------------------------------------------------------------ checks
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            if (n_errors <= 40) begin
                $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
            end
        end
    endtask

    // ------------------------------------------------------- reference model
    int          cyc = 0;
    int          m_phase;        // 0 idle, 1 issuing, 2 draining, 3 done pulse
    int          m_atomic, m_out, m_total, m_issued, m_popped;
    int          m_due[$];       // cycle in which each in-flight result returns
    logic [31:0] m_grp_acc;
    int          m_grp_n;
    logic [31:0] m_q[$];         // expected FIFO contents
    logic [31:0] m_last;
    bit          m_err, m_bad_done;

    task automatic model_reset();
        m_phase = 0; m_atomic = 1; m_out = 0; m_total = 0;
        m_issued = 0; m_popped = 0; m_grp_acc = '0; m_grp_n = 0;
        m_due.delete(); m_q.delete(); m_last = '0; m_err = 0; m_bad_done = 0;
    endtask

    // Credits seen at group level: groups started minus groups popped.
    function automatic bit exp_ready();
        if (m_phase != 1 || m_issued >= m_total) return 1'b0;
        if ((m_issued % m_atomic) != 0) return 1'b1;
        return ((m_issued / m_atomic) - m_popped) < OFIFO_DEPTH;
    endfunction

    task automatic model_step();
        int  phase0;
        bit  q_empty0, due_empty0, rdy, bad_next;
        longint s;
        phase0     = m_phase;
        q_empty0   = (m_q.size() == 0);
        due_empty0 = (m_due.size() == 0);
        rdy        = exp_ready();
        bad_next   = 0;
        if (!q_empty0 && dp2accu_ready) begin
            m_last = m_q.pop_front();
            m_popped++;
        end
        if (!due_empty0 && m_due[0] == cyc) begin
            void'(m_due.pop_front());
            if (m_grp_n == 0) begin
                m_grp_acc = tree2ctrl_sum;
            end else begin
                s = longint'($signed(m_grp_acc)) + longint'($signed(tree2ctrl_sum));
                if (s > 64'sd2147483647 || s < -64'sd2147483648) m_err = 1;
                m_grp_acc = m_grp_acc + tree2ctrl_sum;
            end
            m_grp_n++;
            if (m_grp_n == m_atomic) begin
                m_q.push_back(m_grp_acc);
                m_grp_n = 0;
            end
        end
        if (rdy && cmac2ctrl_valid) begin
            m_issued++;
            m_due.push_back(cyc + TREE_LAT);
        end
        case (phase0)
            0: if (cfg_start) begin
                if (cfg_atomic_num != 0 && cfg_out_num != 0) begin
                    m_atomic = cfg_atomic_num; m_out = cfg_out_num;
                    m_total = m_atomic * m_out; m_issued = 0; m_popped = 0;
                    m_grp_n = 0; m_err = 0; m_phase = 1;
                end else begin
                    m_err = 1; bad_next = 1;
                end
            end
            1: if (rdy && cmac2ctrl_valid && m_issued == m_total) m_phase = 2;
            2: if (due_empty0 && q_empty0) m_phase = 3;
            default: m_phase = 0;
        endcase
        m_bad_done = bad_next;
    endtask

    // ---------------------------------------------------------- stimulus
    bit          d_rst = 1;
    bit          d_start = 0;
    int          d_atomic = 1, d_out = 1;
    int          valid_pct = 100, ready_pct = 100, noise_pct = 0;
    logic [31:0] dir_sums[$];
    logic [31:0] obs_q[$];
    int          hs_count, done_count, first_valid_cyc, start_cyc;

    function automatic logic [31:0] rand_sum();
        case ($urandom_range(3))
            0:       return 32'($urandom_range(100));
            1:       return 32'h7FFF_FF00 + 32'($urandom_range(255));
            2:       return 32'h8000_0000 + 32'($urandom_range(255));
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [63:0] obs_at(input int i);
        if (i < obs_q.size()) return 64'(obs_q[i]);
        return 64'hBAD0_BAD0_BAD0_BAD0;
    endfunction

    task automatic cycle();
        bit exp_v;
        @(posedge clk);
        #1;
        cyc++;
        rst             = d_rst;
        cfg_start       = d_start;
        cfg_atomic_num  = CNT_W'(d_atomic);
        cfg_out_num     = OUT_CNT_W'(d_out);
        if (!d_start && m_phase != 0 && $urandom_range(99) < noise_pct) begin
            cfg_start      = 1'b1;
            cfg_atomic_num = CNT_W'($urandom_range(3));
            cfg_out_num    = OUT_CNT_W'($urandom_range(3));
        end
        if (d_start) start_cyc = cyc;
        d_start         = 0;
        cmac2ctrl_valid = ($urandom_range(99) < valid_pct);
        dp2accu_ready   = ($urandom_range(99) < ready_pct);
        if (m_due.size() > 0 && m_due[0] == cyc && dir_sums.size() > 0)
            tree2ctrl_sum = dir_sums.pop_front();
        else
            tree2ctrl_sum = rand_sum();
        @(negedge clk);
        if (rst) begin
            model_reset();
        end else begin
            exp_v = (m_q.size() != 0);
            check("ready", 64'(ctrl2cmac_ready), 64'(exp_ready()));
            check("valid", 64'(accu2dp_valid), 64'(exp_v));
            check("data",  64'(accu2dp_data), exp_v ? 64'(m_q[0]) : 64'(m_last));
            check("busy",  64'(ctrl_busy), 64'(m_phase != 0));
            check("done",  64'(ctrl_done), 64'(m_phase == 3 || m_bad_done));
            check("err",   64'(ctrl_err), 64'(m_err));
            if (accu2dp_valid && dp2accu_ready) obs_q.push_back(accu2dp_data);
            if (accu2dp_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (ctrl2cmac_ready && cmac2ctrl_valid) hs_count++;
            if (ctrl_done) done_count++;
            model_step();
        end
    endtask

    task automatic clear_obs();
        obs_q.delete(); dir_sums.delete();
        hs_count = 0; done_count = 0; first_valid_cyc = -1;
    endtask

    task automatic start_layer(input int a, input int o);
        d_atomic = a; d_out = o; d_start = 1;
        cycle();
    endtask

    task automatic run_until_idle(input int budget);
        int k = 0;
        while ((m_phase != 0 || m_bad_done) && k < budget) begin
            cycle();
            k++;
        end
        check("timeout", 64'(m_phase != 0), 64'd0);
        cycle();
    endtask

    initial begin
        #900_000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        rst = 1'b1; cfg_start = 1'b0; cfg_atomic_num = '0; cfg_out_num = '0;
        cmac2ctrl_valid = 1'b0; tree2ctrl_sum = '0; dp2accu_ready = 1'b0;
        model_reset();
        clear_obs();

        // Reset state
        d_rst = 1; cycle(); cycle();
        d_rst = 0; cycle();
        check("rst_ready", 64'(ctrl2cmac_ready), 64'd0);
        check("rst_valid", 64'(accu2dp_valid), 64'd0);
        check("rst_data",  64'(accu2dp_data), 64'd0);
        check("rst_busy",  64'(ctrl_busy), 64'd0);
        check("rst_done",  64'(ctrl_done), 64'd0);
        check("rst_err",   64'(ctrl_err), 64'd0);

        // Basic: 3 sums per element, two elements, sums 1..6
        clear_obs();
        valid_pct = 100; ready_pct = 100;
        for (int i = 1; i <= 6; i++) dir_sums.push_back(32'(i));
        start_layer(3, 2);
        run_until_idle(200);
        check("basic_count", 64'(obs_q.size()), 64'd2);
        check("basic_out0", obs_at(0), 64'd6);
        check("basic_out1", obs_at(1), 64'd15);
        check("basic_latency", 64'(first_valid_cyc - start_cyc), 64'(3 + TREE_LAT + 1));
        check("basic_done_count", 64'(done_count), 64'd1);
        check("basic_busy_after", 64'(ctrl_busy), 64'd0);

        // Backpressure: output stalled, only the credits' worth of issues
        clear_obs();
        ready_pct = 0;
        for (int i = 1; i <= 10; i++) dir_sums.push_back(32'(i));
        start_layer(1, 10);
        for (int i = 0; i < 40; i++) cycle();
        check("bp_issues", 64'(hs_count), 64'(OFIFO_DEPTH));
        check("bp_full_ready", 64'(ctrl2cmac_ready), 64'd0);
        check("bp_full_valid", 64'(accu2dp_valid), 64'd1);
        ready_pct = 100;
        run_until_idle(400);
        check("bp_count", 64'(obs_q.size()), 64'd10);
        for (int i = 0; i < 10; i++) check("bp_order", obs_at(i), 64'(i + 1));

        // Fill the FIFO, then release the output with push and pop together
        clear_obs();
        ready_pct = 0;
        start_layer(1, 24);
        for (int i = 0; i < 20; i++) cycle();
        ready_pct = 100;
        run_until_idle(400);
        check("pp_count", 64'(obs_q.size()), 64'd24);
        check("pp_issues", 64'(hs_count), 64'd24);

        // Signed overflow
        clear_obs();
        dir_sums.push_back(32'h7FFF_FFFF);
        dir_sums.push_back(32'h0000_0001);
        start_layer(2, 1);
        run_until_idle(200);
        check("ovf_out", obs_at(0), 64'h8000_0000);
        check("ovf_err", 64'(ctrl_err), 64'd1);
        clear_obs();
        start_layer(1, 1);
        cycle();
        check("ovf_err_clear", 64'(ctrl_err), 64'd0);
        run_until_idle(200);

        // Bad configuration
        clear_obs();
        start_layer(0, 3);
        cycle();
        check("bad_done", 64'(ctrl_done), 64'd1);
        check("bad_err", 64'(ctrl_err), 64'd1);
        check("bad_busy", 64'(ctrl_busy), 64'd0);
        check("bad_ready", 64'(ctrl2cmac_ready), 64'd0);
        cycle();
        check("bad_done_once", 64'(ctrl_done), 64'd0);
        start_layer(2, 0);
        run_until_idle(20);

        // Reset in the middle of a layer
        clear_obs();
        start_layer(3, 4);
        for (int i = 0; i < 3; i++) cycle();
        d_rst = 1; cycle();
        d_rst = 0; cycle();
        check("mid_rst_busy", 64'(ctrl_busy), 64'd0);
        check("mid_rst_valid", 64'(accu2dp_valid), 64'd0);
        clear_obs();
        dir_sums.push_back(32'd5);
        dir_sums.push_back(32'd7);
        start_layer(2, 1);
        run_until_idle(200);
        check("mid_rst_count", 64'(obs_q.size()), 64'd1);
        check("mid_rst_out", obs_at(0), 64'd12);
        check("mid_rst_done", 64'(done_count), 64'd1);

        // Random layers with random handshakes and stray start pulses
        noise_pct = 5;
        for (int l = 0; l < 14; l++) begin
            clear_obs();
            valid_pct = $urandom_range(30, 100);
            ready_pct = $urandom_range(20, 100);
            if ($urandom_range(9) == 0) start_layer(0, $urandom_range(1, 4));
            else start_layer($urandom_range(1, 4), $urandom_range(1, 6));
            run_until_idle(3000);
        end
        noise_pct = 0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
